imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that fetch reads from.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one-cycle imem write strobes at consecutive word addresses.
- Verifies a trailing additive checksum.
- Holds the CPU in reset (cpu_hold) until the image is loaded and verified.

Parameters:
BASE_ADDR, 32'h01000000, byte address of the first instruction word written
MAX_WORDS, 262144, largest accepted word count; a larger count is an error

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
byte_valid  input  1  byte_data holds a valid byte
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
imem_write  output  1  1 = write imem_data to imem_addr this cycle; 0 = read (drives read_write_imem)
imem_addr  output  32  imem byte address, word aligned
imem_data  output  32  imem write data (drives imem data_in)
cpu_hold  output  1  1 = keep CPU pipeline in reset; OR-ed into the cpu reset
done  output  1  image loaded and checksum matched
error  output  1  bad length or checksum mismatch

Behaviour:
- Reset values (while reset is high and the cycle after): state=S_LEN, imem_write=0, imem_addr=BASE_ADDR, imem_data=0, cpu_hold=1, done=0, error=0, word index=0, sum=0, byte counter=0.
- byte_ready is decoded from state: 1 in S_LEN, S_DATA and S_CSUM; 0 in S_WRITE, S_DONE and S_ERR; forced 0 while reset is high.
- Byte transfer occurs only on a rising edge with byte_valid && byte_ready. byte_data is ignored otherwise. Gaps in byte_valid are allowed anywhere.
- Word assembly uses a 2-bit byte counter, little-endian: the first byte goes to [7:0], the fourth to [31:24]. The counter wraps to 0 after the fourth byte.
- S_LEN: collect 4 bytes into count.
  - count==0 -> S_CSUM.
  - count>MAX_WORDS -> S_ERR.
  - else -> S_DATA.
- S_DATA: on the 4th byte, register imem_data=word and imem_addr=BASE_ADDR+4*index, then go to S_WRITE.
- S_WRITE: lasts exactly one cycle with imem_write=1. On exit: index+=1 and sum=(sum+imem_data) mod 2^32.
  - index==count -> S_CSUM.
  - else -> S_DATA.
  - imem_write is 0 in every other state.
- Write latency: the write strobe is asserted in the cycle after the 4th byte of a word is accepted.
- S_CSUM: collect 4 bytes.
  - Equal to sum -> S_DONE.
  - Else -> S_ERR.
- S_DONE: done=1 and cpu_hold=0, both registered and first asserted on the cycle after the last checksum byte.
- S_ERR: error=1 and cpu_hold stays 1.
- S_DONE and S_ERR are terminal until reset. done and error are never both 1.
- Sum wrap-around is modulo 2^32 with no overflow flag.
- Address arithmetic is 32-bit. MAX_WORDS bounds the top address; no address wrap checks are made.
- Reset mid-operation: the partial word is discarded, no write strobe is issued, and the next byte is treated as length byte 0.
- imem_addr and imem_data hold their last values outside S_WRITE.

Test Plan:
1. Normal load: count=2, words 0x00000013, 0xDEADBEEF, checksum 0xDEADBF02, all bytes little-endian.
   - Required: imem_write pulses at 0x01000000/0x00000013 and at 0x01000004/0xDEADBEEF.
   - Required: done=1 and cpu_hold=0 one cycle after the last byte.
2. Bad checksum: same image with checksum 0xDEADBF03.
   - Required: error=1, done=0, cpu_hold stays 1, byte_ready=0 thereafter.
3. Empty image: count=0 then checksum 0x00000000.
   - Required: no imem_write pulse, done=1.
4. Oversize: count=MAX_WORDS+1.
   - Required: error=1 on the cycle after the 4th length byte, no writes, byte_ready=0.
5. Handshake stress: random byte_valid gaps; byte_valid held high through S_WRITE.
   - Required: byte_ready=0 during the write cycle and no byte lost.
   - Required: wrap-sum image 0xFFFFFFFF, 0x00000002 with checksum 0x00000001 gives done=1.
6. Reset mid-DATA: reset asserted after 2 data bytes.
   - Required: all outputs return to reset values and no write is issued.
   - Required: a full reload of scenario 1 then completes with done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a little-endian byte stream
// (length, words, checksum) and writes imem. The CPU is held in reset until the checksum verifies.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h01000000,
  parameter int unsigned MAX_WORDS = 262144
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        o_imem_write,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_data,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] MAX_COUNT = 32'(MAX_WORDS);

  state_t      r_state;
  logic [1:0]  r_byteCnt;
  logic [31:0] r_shift;
  logic [31:0] r_count;
  logic [31:0] r_index;
  logic [31:0] r_sum;
  logic [31:0] r_imemAddr;
  logic [31:0] r_imemData;
  logic        r_imemWrite;
  logic        r_cpuHold;
  logic        r_done;
  logic        r_error;

  logic        w_stateReady;
  logic        w_accept;
  logic        w_lastByte;
  logic [31:0] w_word;
  logic [31:0] w_nextIndex;

  always_comb begin
    w_stateReady = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
  end

  assign o_byte_ready = w_stateReady && !i_reset;
  assign w_accept     = i_byte_valid && o_byte_ready;
  assign w_lastByte   = w_accept && (r_byteCnt == 2'd3);
  // Bytes enter at the top and shift down, so the first byte lands in [7:0].
  assign w_word       = {i_byte_data, r_shift[31:8]};
  assign w_nextIndex  = r_index + 32'd1;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_LEN;
      r_byteCnt   <= 2'd0;
      r_shift     <= 32'd0;
      r_count     <= 32'd0;
      r_index     <= 32'd0;
      r_sum       <= 32'd0;
      r_imemAddr  <= BASE_ADDR;
      r_imemData  <= 32'd0;
      r_imemWrite <= 1'b0;
      r_cpuHold   <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift   <= w_word;
        r_byteCnt <= r_byteCnt + 2'd1;
      end
      case (r_state)
        S_LEN: begin
          if (w_lastByte) begin
            r_count <= w_word;
            if (w_word == 32'd0) begin
              r_state <= S_CSUM;
            end else if (w_word > MAX_COUNT) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_lastByte) begin
            r_imemData  <= w_word;
            r_imemAddr  <= BASE_ADDR + {r_index[29:0], 2'b00};
            r_imemWrite <= 1'b1;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_imemWrite <= 1'b0;
          r_index     <= w_nextIndex;
          r_sum       <= r_sum + r_imemData;
          r_state     <= (w_nextIndex == r_count) ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          if (w_lastByte) begin
            if (w_word == r_sum) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_cpuHold <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_ERR;
          r_error <= 1'b1;
        end
      endcase
    end
  end

  assign o_imem_write = r_imemWrite;
  assign o_imem_addr  = r_imemAddr;
  assign o_imem_data  = r_imemData;
  assign o_cpu_hold   = r_cpuHold;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: randomized byte gaps and images, expected writes
// queued by the driver and popped by an independent monitor.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h01000000;
  localparam int unsigned MAXW = 262144;

  logic        clock = 1'b0;
  logic        reset;
  logic        byteValid;
  logic [7:0]  byteData;
  logic        byteReady;
  logic        imemWrite;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        cpuHold;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_byte_valid (byteValid),
    .i_byte_data  (byteData),
    .o_byte_ready (byteReady),
    .o_imem_write (imemWrite),
    .o_imem_addr  (imemAddr),
    .o_imem_data  (imemData),
    .o_cpu_hold   (cpuHold),
    .o_done       (done),
    .o_error      (error)
  );

  int          tests = 0;
  int          fails = 0;
  int          writesSeen = 0;
  int          gapMax = 0;
  logic [63:0] expQ[$];
  logic [63:0] monEntry;
  logic [31:0] img[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (imemWrite === 1'b1) begin
        writesSeen++;
        checkOutput("ready low in write cycle", {31'd0, byteReady}, 32'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected write addr", imemAddr, 32'hxxxxxxxx);
        end else begin
          monEntry = expQ.pop_front();
          checkOutput("write addr", imemAddr, monEntry[63:32]);
          checkOutput("write data", imemData, monEntry[31:0]);
        end
      end
      if (done === 1'b1 && error === 1'b1) checkOutput("done/error exclusive", 32'd1, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doReset();
    byteValid = 1'b0;
    byteData  = 8'h00;
    reset     = 1'b1;
    expQ.delete();
    writesSeen = 0;
    repeat (2) @(negedge clock);
    checkOutput("rst ready", {31'd0, byteReady}, 32'd0);
    checkOutput("rst write", {31'd0, imemWrite}, 32'd0);
    checkOutput("rst addr", imemAddr, BASE);
    checkOutput("rst data", imemData, 32'd0);
    checkOutput("rst hold", {31'd0, cpuHold}, 32'd1);
    checkOutput("rst done", {31'd0, done}, 32'd0);
    checkOutput("rst error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post-rst ready", {31'd0, byteReady}, 32'd1);
    checkOutput("post-rst hold", {31'd0, cpuHold}, 32'd1);
    checkOutput("post-rst addr", imemAddr, BASE);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic sendByte(input logic [7:0] b);
    int gap;
    int waits;
    gap = $urandom_range(0, gapMax);
    repeat (gap) begin
      byteValid = 1'b0;
      byteData  = 8'($urandom);
      @(negedge clock);
    end
    byteValid = 1'b1;
    byteData  = b;
    waits = 0;
    while (byteReady !== 1'b1 && waits < 20) begin
      @(negedge clock);
      waits++;
    end
    if (waits >= 20) begin
      checkOutput("byte_ready timeout", 32'd0, 32'd1);
      byteValid = 1'b0;
    end else begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8]);
  endtask

  // Reference model: writes go to BASE + 4*i, outcome is done iff the
  // length is in range and csum equals the 32-bit wrapping sum of the words.
  task automatic applyStimulus(input logic [31:0] count, input logic [31:0] csum);
    logic [31:0] sum;
    logic        expDone;
    sum = 32'd0;
    foreach (img[i]) sum = sum + img[i];
    expDone = (count <= MAXW) && (csum == sum);
    doReset();
    sendWord(count);
    if (count > MAXW) begin
      checkOutput("oversize error", {31'd0, error}, 32'd1);
      checkOutput("oversize ready", {31'd0, byteReady}, 32'd0);
      checkOutput("oversize done", {31'd0, done}, 32'd0);
    end else begin
      for (int i = 0; i < int'(count); i++) begin
        for (int k = 0; k < 4; k++) begin
          if (k == 3) expQ.push_back({BASE + 32'(4 * i), img[i]});
          sendByte(img[i][8*k +: 8]);
        end
        checkOutput("write latency", {31'd0, imemWrite}, 32'd1);
      end
      sendWord(csum);
      checkOutput("final done", {31'd0, done}, {31'd0, expDone});
      checkOutput("final error", {31'd0, error}, {31'd0, !expDone});
      checkOutput("final hold", {31'd0, cpuHold}, {31'd0, !expDone});
    end
    byteValid = 1'b1;
    byteData  = 8'hA5;
    repeat (3) @(negedge clock);
    byteValid = 1'b0;
    checkOutput("terminal ready", {31'd0, byteReady}, 32'd0);
    checkOutput("terminal done", {31'd0, done}, {31'd0, expDone});
    checkOutput("pending writes", expQ.size(), 32'd0);
    checkOutput("write count", writesSeen, (count > MAXW) ? 32'd0 : count);
  endtask

  initial begin
    logic [31:0] cnt;
    logic [31:0] s;
    reset = 1'b1;
    byteValid = 1'b0;
    byteData = 8'h00;
    @(negedge clock);

    // Normal load, then bad checksum, with no gaps.
    img = '{32'h00000013, 32'hDEADBEEF};
    applyStimulus(32'd2, 32'hDEADBF02);
    applyStimulus(32'd2, 32'hDEADBF03);

    // Empty image and oversize length.
    img = '{};
    applyStimulus(32'd0, 32'h00000000);
    applyStimulus(32'(MAXW) + 32'd1, 32'h00000000);

    // Largest legal length is accepted.
    doReset();
    sendWord(32'(MAXW));
    checkOutput("max count no error", {31'd0, error}, 32'd0);
    checkOutput("max count ready", {31'd0, byteReady}, 32'd1);

    // Handshake stress with gaps, including a wrapping sum.
    gapMax = 3;
    img = '{32'hFFFFFFFF, 32'h00000002};
    applyStimulus(32'd2, 32'h00000001);
    for (int n = 0; n < 6; n++) begin
      cnt = 32'($urandom_range(1, 6));
      img = '{};
      s = 32'd0;
      for (int i = 0; i < int'(cnt); i++) begin
        img.push_back($urandom);
        s = s + img[i];
      end
      if ($urandom_range(0, 1) == 1) s = s ^ (32'd1 << $urandom_range(0, 31));
      applyStimulus(cnt, s);
    end

    // Reset in the middle of a data word.
    gapMax = 0;
    doReset();
    sendWord(32'd2);
    sendByte(8'h13);
    sendByte(8'h00);
    doReset();
    repeat (3) @(negedge clock);
    checkOutput("no write after mid reset", writesSeen, 32'd0);
    img = '{32'h00000013, 32'hDEADBEEF};
    applyStimulus(32'd2, 32'hDEADBF02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
